// File: rtl/button_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel button debouncer.
package button_pkg;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

   typedef struct packed {
      logic level;
      logic press;
      logic rel;
      logic rpt;
   } chan_out_t;

   localparam longint unsigned MICROS_PER_SEC = 64'd1_000_000;

   // Microseconds to clock cycles, evaluated with 64-bit intermediates.
   function automatic longint unsigned micro_to_cycles(input longint unsigned clk_hz,
                                                       input longint unsigned micro);
      return (clk_hz * micro) / MICROS_PER_SEC;
   endfunction

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input longint unsigned max_val);
      return (max_val == 64'd0) ? 32'd1 : 32'($clog2(max_val + 64'd1));
   endfunction

endpackage

// File: rtl/multi_button_debouncer_if.sv
// Bundle of raw button levels and the debounced level/event vectors.
interface multi_button_debouncer_if #(
   parameter int unsigned CHANNELS = 4
);
   logic [CHANNELS-1:0] buttons;
   logic [CHANNELS-1:0] level;
   logic [CHANNELS-1:0] press;
   logic [CHANNELS-1:0] rel;
   logic [CHANNELS-1:0] rpt;

   modport master (output buttons, input level, press, rel, rpt);
   modport slave  (input buttons, output level, press, rel, rpt);
endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability filter, edge pulses and
// auto-repeat FSM. All outputs are registered.
module debounce_channel
   import button_pkg::*;
#(
   parameter longint unsigned FILTER_CYC = 64'd1,
   parameter longint unsigned DELAY_CYC  = 64'd1,
   parameter longint unsigned RATE_CYC   = 64'd1,
   parameter bit              REPEAT_EN  = 1'b1,
   parameter bit              ACTIVE_LOW = 1'b0
)(
   input  logic      clk,
   input  logic      rst,
   input  logic      button,
   output chan_out_t out
);

   // A zero filter length behaves exactly like a length of one.
   localparam longint unsigned FILT_LIM = (FILTER_CYC == 64'd0) ? 64'd1 : FILTER_CYC;
   localparam int unsigned     FILT_W   = cnt_width(FILT_LIM);

   logic              sync_meta;
   logic              sync;
   logic              level;
   logic              press;
   logic              rel;
   logic              rpt;
   logic [FILT_W-1:0] filt_cnt;
   logic              toggle_c;

   assign toggle_c = (sync != level) && (filt_cnt == FILT_W'(FILT_LIM - 64'd1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
         filt_cnt  <= '0;
         level     <= 1'b0;
         press     <= 1'b0;
         rel       <= 1'b0;
      end else begin
         sync_meta <= button ^ ACTIVE_LOW;
         sync      <= sync_meta;
         if ((sync == level) || toggle_c)
            filt_cnt <= '0;
         else
            filt_cnt <= filt_cnt + FILT_W'(1);
         level <= level ^ toggle_c;
         press <= toggle_c & ~level;
         rel   <= toggle_c & level;
      end
   end

   generate
      if (REPEAT_EN) begin : g_rpt
         localparam longint unsigned DELAY_LIM = (DELAY_CYC == 64'd0) ? 64'd1 : DELAY_CYC;
         localparam longint unsigned RATE_LIM  = (RATE_CYC == 64'd0) ? 64'd1 : RATE_CYC;
         localparam longint unsigned HOLD_MAX  = (DELAY_LIM > RATE_LIM) ? DELAY_LIM : RATE_LIM;
         localparam int unsigned     HOLD_W    = cnt_width(HOLD_MAX);

         rpt_state_t        state;
         logic [HOLD_W-1:0] hold_cnt;

         // A debounced release (toggle while pressed) always wins over a repeat pulse.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state    <= RPT_IDLE;
               hold_cnt <= '0;
               rpt      <= 1'b0;
            end else begin
               rpt <= 1'b0;
               case (state)
                  RPT_IDLE: begin
                     hold_cnt <= '0;
                     if (toggle_c && !level)
                        state <= RPT_DELAY;
                  end
                  RPT_DELAY: begin
                     if (toggle_c) begin
                        state    <= RPT_IDLE;
                        hold_cnt <= '0;
                     end else if (hold_cnt == HOLD_W'(DELAY_LIM - 64'd1)) begin
                        rpt      <= 1'b1;
                        state    <= RPT_REPEAT;
                        hold_cnt <= '0;
                     end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                     end
                  end
                  RPT_REPEAT: begin
                     if (toggle_c) begin
                        state    <= RPT_IDLE;
                        hold_cnt <= '0;
                     end else if (hold_cnt == HOLD_W'(RATE_LIM - 64'd1)) begin
                        rpt      <= 1'b1;
                        hold_cnt <= '0;
                     end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                     end
                  end
                  default: begin
                     state    <= RPT_IDLE;
                     hold_cnt <= '0;
                  end
               endcase
            end
         end
      end else begin : g_no_rpt
         assign rpt = 1'b0;
      end
   endgenerate

   assign out = {level, press, rel, rpt};

endmodule

// File: rtl/multi_button_debouncer.sv
// Top level: converts timing parameters to cycle counts and instantiates one
// independent debounce channel per button.
module multi_button_debouncer
   import button_pkg::*;
#(
   parameter int unsigned     CHANNELS             = 4,
   parameter longint unsigned c_CLK_FREQ           = 106470000,
   parameter longint unsigned c_FILTER_MICRO       = 5000,
   parameter longint unsigned c_REPEAT_DELAY_MICRO = 500000,
   parameter longint unsigned c_REPEAT_RATE_MICRO  = 100000,
   parameter bit              c_ACTIVE_LOW         = 1'b0
)(
   input  logic                i_Clk,
   input  logic                i_Reset,
   input  logic [CHANNELS-1:0] i_Buttons,
   output logic [CHANNELS-1:0] o_Buttons,
   output logic [CHANNELS-1:0] o_Press,
   output logic [CHANNELS-1:0] o_Release,
   output logic [CHANNELS-1:0] o_Repeat
);

   localparam longint unsigned FILTER_CYC = micro_to_cycles(c_CLK_FREQ, c_FILTER_MICRO);
   localparam longint unsigned DELAY_CYC  = micro_to_cycles(c_CLK_FREQ, c_REPEAT_DELAY_MICRO);
   localparam longint unsigned RATE_CYC   = micro_to_cycles(c_CLK_FREQ, c_REPEAT_RATE_MICRO);
   localparam bit              REPEAT_EN  = (c_REPEAT_DELAY_MICRO != 64'd0);

   chan_out_t ch_out [CHANNELS];

   multi_button_debouncer_if #(.CHANNELS(CHANNELS)) bus ();

   assign bus.buttons = i_Buttons;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .FILTER_CYC (FILTER_CYC),
         .DELAY_CYC  (DELAY_CYC),
         .RATE_CYC   (RATE_CYC),
         .REPEAT_EN  (REPEAT_EN),
         .ACTIVE_LOW (c_ACTIVE_LOW)
      ) u_chan (
         .clk    (i_Clk),
         .rst    (i_Reset),
         .button (bus.buttons[g]),
         .out    (ch_out[g])
      );

      assign bus.level[g] = ch_out[g].level;
      assign bus.press[g] = ch_out[g].press;
      assign bus.rel[g]   = ch_out[g].rel;
      assign bus.rpt[g]   = ch_out[g].rpt;
   end

   assign o_Buttons = bus.level;
   assign o_Press   = bus.press;
   assign o_Release = bus.rel;
   assign o_Repeat  = bus.rpt;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Scoreboard bench: stimulus queues expected pulses with their cycle stamps,
// a negedge monitor matches every DUT pulse and tracks the expected levels.
module tb_multi_button_debouncer;

   localparam int unsigned NCH     = 4;
   localparam int          LAT     = 12;
   localparam int          DELAY_C = 50;
   localparam int          RATE_C  = 20;
   localparam int          K_PRESS = 0;
   localparam int          K_REL   = 1;
   localparam int          K_RPT   = 2;

   typedef struct {
      int cyc;
      int d;
      int k;
      int ch;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   ev_t  exp_q[$];
   logic [NCH-1:0] exp_level [2];

   multi_button_debouncer_if #(.CHANNELS(NCH)) bus0 ();
   multi_button_debouncer_if #(.CHANNELS(NCH)) bus1 ();

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multi_button_debouncer #(
      .CHANNELS(NCH), .c_CLK_FREQ(1000000), .c_FILTER_MICRO(10),
      .c_REPEAT_DELAY_MICRO(50), .c_REPEAT_RATE_MICRO(20), .c_ACTIVE_LOW(1'b0)
   ) dut (
      .i_Clk(clk), .i_Reset(rst), .i_Buttons(bus0.buttons), .o_Buttons(bus0.level),
      .o_Press(bus0.press), .o_Release(bus0.rel), .o_Repeat(bus0.rpt)
   );

   multi_button_debouncer #(
      .CHANNELS(NCH), .c_CLK_FREQ(1000000), .c_FILTER_MICRO(10),
      .c_REPEAT_DELAY_MICRO(0), .c_REPEAT_RATE_MICRO(20), .c_ACTIVE_LOW(1'b1)
   ) dut_al (
      .i_Clk(clk), .i_Reset(rst), .i_Buttons(bus1.buttons), .o_Buttons(bus1.level),
      .o_Press(bus1.press), .o_Release(bus1.rel), .o_Repeat(bus1.rpt)
   );

   function automatic int ev_key(input ev_t e);
      return e.cyc * 64 + e.d * 16 + e.k * 4 + e.ch;
   endfunction

   function automatic string kname(input int k);
      return (k == K_PRESS) ? "press" : (k == K_REL) ? "release" : "repeat";
   endfunction

   function automatic logic [NCH-1:0] pulses(input int d, input int k);
      if (d == 0)
         return (k == K_PRESS) ? bus0.press : (k == K_REL) ? bus0.rel : bus0.rpt;
      return (k == K_PRESS) ? bus1.press : (k == K_REL) ? bus1.rel : bus1.rpt;
   endfunction

   // Keep the queue ordered the same way the monitor scans outputs.
   task automatic push_ev(input int c, input int d, input int k, input int ch);
      ev_t e;
      int  i;
      e = '{c, d, k, ch};
      i = exp_q.size();
      while (i > 0 && ev_key(exp_q[i-1]) > ev_key(e)) i--;
      exp_q.insert(i, e);
   endtask

   always @(negedge clk) begin
      logic [NCH-1:0] v;
      logic [NCH-1:0] lv;
      if (rst) begin
         exp_level[0] = '0;
         exp_level[1] = '0;
      end
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 3; k++) begin
            v = pulses(d, k);
            for (int ch = 0; ch < int'(NCH); ch++) begin
               if (v[ch]) begin
                  n_checks++;
                  if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].d == d &&
                      exp_q[0].k == k && exp_q[0].ch == ch) begin
                     void'(exp_q.pop_front());
                     if (k == K_PRESS) exp_level[d][ch] = 1'b1;
                     else if (k == K_REL) exp_level[d][ch] = 1'b0;
                  end else begin
                     n_fail++;
                     $display("FAIL unexpected_pulse: dut%0d %s ch%0d at cycle %0d, got 1 required 0",
                              d, kname(k), ch, cyc);
                  end
               end
            end
         end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         n_checks++;
         n_fail++;
         $display("FAIL missing_pulse: dut%0d %s ch%0d due at cycle %0d, got 0 required 1 (now %0d)",
                  exp_q[0].d, kname(exp_q[0].k), exp_q[0].ch, exp_q[0].cyc, cyc);
         void'(exp_q.pop_front());
      end
      for (int d = 0; d < 2; d++) begin
         lv = (d == 0) ? bus0.level : bus1.level;
         n_checks++;
         if (lv !== exp_level[d]) begin
            n_fail++;
            $display("FAIL level: dut%0d cycle %0d got %b required %b", d, cyc, lv, exp_level[d]);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold one dut0 channel for 'hold' cycles and queue press, repeats and release.
   task automatic hold_ch(input int ch, input int hold);
      int t;
      t = cyc;
      bus0.buttons[ch] = 1'b1;
      push_ev(t + LAT, 0, K_PRESS, ch);
      for (int r = t + LAT + DELAY_C; r < t + LAT + hold; r += RATE_C)
         push_ev(r, 0, K_RPT, ch);
      step(hold);
      bus0.buttons[ch] = 1'b0;
      push_ev(t + hold + LAT, 0, K_REL, ch);
   endtask

   initial begin
      int t;
      bus0.buttons = '0;
      bus1.buttons = '1;
      rst = 1'b1;
      step(3);
      n_checks++;
      if ({bus0.level, bus0.press, bus0.rel, bus0.rpt,
           bus1.level, bus1.press, bus1.rel, bus1.rpt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got nonzero outputs required all 0");
      end
      rst = 1'b0;
      step(3);

      // Clean press on ch0.
      hold_ch(0, 20);
      step(30);

      // ch1 bounces every 3 cycles, then settles high.
      for (int i = 0; i < 10; i++) begin
         bus0.buttons[1] = ~bus0.buttons[1];
         step(3);
      end
      bus0.buttons[1] = 1'b1;
      push_ev(cyc + LAT, 0, K_PRESS, 1);
      step(20);
      bus0.buttons[1] = 1'b0;
      push_ev(cyc + LAT, 0, K_REL, 1);
      step(30);

      // Long hold with auto-repeat, then releases landing on would-be repeat cycles.
      hold_ch(2, 200);
      step(30);
      hold_ch(0, 130);
      step(30);
      hold_ch(1, 50);
      step(30);

      // All channels together, ch3 only a 9-cycle glitch.
      t = cyc;
      bus0.buttons = 4'b1111;
      for (int ch = 0; ch < 3; ch++) push_ev(t + LAT, 0, K_PRESS, ch);
      step(9);
      bus0.buttons[3] = 1'b0;
      step(21);
      bus0.buttons[2:0] = 3'b000;
      for (int ch = 0; ch < 3; ch++) push_ev(cyc + LAT, 0, K_REL, ch);
      step(30);

      // Reset mid-filter, then mid-delay, with the button held throughout.
      bus0.buttons[0] = 1'b1;
      step(7);
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      push_ev(cyc + LAT, 0, K_PRESS, 0);
      step(LAT + 30);
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      push_ev(cyc + LAT, 0, K_PRESS, 0);
      step(22);
      bus0.buttons[0] = 1'b0;
      push_ev(cyc + LAT, 0, K_REL, 0);
      step(30);

      // Active-low instance with repeat disabled.
      bus1.buttons[0] = 1'b0;
      push_ev(cyc + LAT, 1, K_PRESS, 0);
      step(100);
      bus1.buttons[0] = 1'b1;
      push_ev(cyc + LAT, 1, K_REL, 0);
      step(30);

      for (int i = 0; i < 300 && exp_q.size() > 0; i++) step(1);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending events required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_button_debouncer.md
MULTI_BUTTON_DEBOUNCER -- requirements
Module: multi_button_debouncer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent button channels (1..32).
REQ-002 SHALL have parameter c_CLK_FREQ, default 106470000: clock frequency in Hz.
REQ-003 SHALL have parameter c_FILTER_MICRO, default 5000: required stability time in microseconds.
REQ-004 SHALL have parameter c_REPEAT_DELAY_MICRO, default 500000: hold time before the first auto-repeat pulse; 0 disables auto-repeat.
REQ-005 SHALL have parameter c_REPEAT_RATE_MICRO, default 100000: period between subsequent auto-repeat pulses; must be nonzero when repeat is enabled.
REQ-006 SHALL have parameter c_ACTIVE_LOW, default 0: 1 inverts raw inputs so that a pressed button reads as 1 internally.
REQ-007 i_Clk  input  1  single clock; all state on its rising edge.
REQ-008 i_Reset  input  1  asynchronous, active-high reset.
REQ-009 i_Buttons  input  CHANNELS  raw, asynchronous button levels.
REQ-010 o_Buttons  output  CHANNELS  debounced pressed level per channel.
REQ-011 o_Press  output  CHANNELS  one-cycle pulse on each debounced 0->1 transition.
REQ-012 o_Release  output  CHANNELS  one-cycle pulse on each debounced 1->0 transition.
REQ-013 o_Repeat  output  CHANNELS  one-cycle auto-repeat pulses while a channel is held.

Function
REQ-014 Cycle constants SHALL be computed at elaboration: FILTER = c_CLK_FREQ*c_FILTER_MICRO/1e6, DELAY and RATE likewise; 64-bit intermediate arithmetic SHALL be used; counter widths SHALL be clog2 of (max constant + 1).
REQ-015 Each channel SHALL pass its (polarity-corrected) input through a 2-flop synchronizer; only the second flop (sync) feeds the filter.
REQ-016 Channels SHALL be fully independent: each has its own filter counter, so activity on one channel never delays or restarts another.
REQ-017 Filter: while sync == debounced state, the channel counter SHALL be held at 0; while they differ, it increments each cycle.
REQ-018 When the counter equals FILTER-1 and sync still differs, the debounced state SHALL toggle on the next edge and the counter SHALL clear; a sync glitch shorter than FILTER cycles never changes the output.
REQ-019 Latency: a clean input step SHALL appear on o_Buttons exactly FILTER+2 rising edges after it is first sampled.
REQ-020 FILTER = 0 SHALL degenerate to a synchronizer-only path (toggle on the first differing cycle, same as FILTER = 1).
REQ-021 o_Press and o_Release SHALL be registered and SHALL assert in the same cycle that o_Buttons changes, for exactly one cycle.
REQ-022 Repeat FSM per channel, states IDLE, DELAY, REPEAT: IDLE->DELAY on debounced press; in DELAY the hold counter counts to DELAY-1, then o_Repeat pulses and the state moves to REPEAT; in REPEAT o_Repeat pulses every RATE cycles.
REQ-023 Debounced release in any state SHALL return to IDLE and clear the hold counter in that same cycle; no o_Repeat pulse SHALL coincide with o_Release.
REQ-024 o_Press SHALL never coincide with o_Repeat; the first repeat pulse occurs exactly DELAY cycles after the o_Press pulse.
REQ-025 With c_REPEAT_DELAY_MICRO = 0, o_Repeat SHALL be constant 0 and the repeat FSM may be optimised away.
REQ-026 The hold counter SHALL not overflow: in REPEAT it reloads every RATE cycles, so arbitrarily long holds are supported.

Reset
REQ-027 i_Reset SHALL asynchronously clear synchronizer flops, filter counters, hold counters, debounced state (released), and repeat FSM (IDLE).
REQ-028 All outputs SHALL be 0 during and immediately after reset; a button held through reset SHALL produce o_Press FILTER+2 cycles after reset deassertion.
REQ-029 Reset asserted mid-filter or mid-repeat SHALL abort without emitting any pulse.

Structure
REQ-030 The cycle-conversion function and FSM state encodings SHALL live in shared package button_pkg.
REQ-031 Per-channel logic SHALL be sub-module debounce_channel (synchronizer, filter, edge detect, repeat FSM), instantiated CHANNELS times by generate.

Verification (bench: c_CLK_FREQ=1000000, FILTER_MICRO=10, DELAY_MICRO=50, RATE_MICRO=20, CHANNELS=4)
REQ-032 Clean press on ch0 -> o_Buttons[0] rises and o_Press[0] pulses exactly 12 edges later; other channels stay 0.
REQ-033 ch1 bounces (toggles every 3 cycles for 30 cycles, then stable 1) -> exactly one o_Press[1], 12 cycles after the final edge.
REQ-034 ch2 held 200 cycles -> o_Repeat[2] at press+50, +70, +90, ..., then o_Release[2] with no repeat in that cycle.
REQ-035 Simultaneous presses on all channels, ch3 glitch of 9 cycles -> ch0-2 press at +12, ch3 never changes.
REQ-036 Reset asserted 5 cycles into a filter count and 30 cycles into DELAY -> all outputs 0, no pulses; held input re-presses 12 cycles after release of reset.
REQ-037 c_ACTIVE_LOW=1 with input driven 0 -> o_Buttons 1 after 12 cycles; with DELAY_MICRO=0 o_Repeat stays 0 throughout.
